// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD counter stepped by a prescaled CLOCK_50 tick, with up/down,
// parallel load, registered tick/rollover pulses and per-digit 7-segment drive.
module bcd_tick_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                up_down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                tick,
  output logic                rollover,
  output logic [7*DIGITS-1:0] hex
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned HW = 7 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic          step_c;
  logic [CW-1:0] step_count_c;
  logic [CW-1:0] load_clean_c;
  logic          wrap_c;
  logic          chain;
  logic [3:0]    d;
  logic [3:0]    hd;
  logic          lz;

  assign step_c = enable && (prescaler == PRE_MAX);

  // Ripple carry/borrow through the digits; chain surviving past the top digit means wrap.
  always_comb begin
    step_count_c = count;
    load_clean_c = '0;
    chain        = 1'b1;
    d            = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = count[4*i +: 4];
      if (chain) begin
        if (up_down) begin
          if (d == 4'd9) begin
            step_count_c[4*i +: 4] = 4'd0;
          end else begin
            step_count_c[4*i +: 4] = 4'(d + 4'd1);
            chain = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            step_count_c[4*i +: 4] = 4'd9;
          end else begin
            step_count_c[4*i +: 4] = 4'(d - 4'd1);
            chain = 1'b0;
          end
        end
      end
      load_clean_c[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
    end
    wrap_c = chain;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      prescaler <= '0;
      count     <= '0;
      tick      <= 1'b0;
      rollover  <= 1'b0;
    end else if (load) begin
      prescaler <= '0;
      count     <= load_clean_c;
      tick      <= 1'b0;
      rollover  <= 1'b0;
    end else begin
      tick     <= step_c;
      rollover <= step_c && wrap_c;
      if (enable) begin
        prescaler <= step_c ? '0 : prescaler + 1'b1;
      end
      if (step_c) begin
        count <= step_count_c;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0011000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Scan from the top digit so lz tracks "this digit and all above are zero".
  always_comb begin
    hex = {HW{1'b1}};
    lz  = 1'b1;
    hd  = 4'd0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      hd = count[4*i +: 4];
      lz = lz && (hd == 4'd0);
      if ((BLANK_LZ != 0) && (i > 0) && lz) begin
        hex[7*i +: 7] = 7'b1111111;
      end else begin
        hex[7*i +: 7] = seg7(hd);
      end
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter: a 2-digit counter (TICK_DIV=4) and a
// 4-digit leading-zero-blanking instance for the display path.
module tb_bcd_tick_counter;

  logic        CLOCK_50;
  logic        reset;
  logic        enable;
  logic        up_down;
  logic        load;
  logic [7:0]  load_value;
  logic [7:0]  count;
  logic        tick;
  logic        rollover;
  logic [13:0] hex;

  logic        enable_b;
  logic        up_down_b;
  logic        load_b;
  logic [15:0] load_value_b;
  logic [15:0] count_b;
  logic        tick_b;
  logic        rollover_b;
  logic [27:0] hex_b;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] SB = 7'b1111111;

  bcd_tick_counter #(.DIGITS(2), .TICK_DIV(4), .BLANK_LZ(0)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .count(count), .tick(tick),
    .rollover(rollover), .hex(hex)
  );

  bcd_tick_counter #(.DIGITS(4), .TICK_DIV(4), .BLANK_LZ(1)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable_b), .up_down(up_down_b),
    .load(load_b), .load_value(load_value_b), .count(count_b), .tick(tick_b),
    .rollover(rollover_b), .hex(hex_b)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = 8'h00;
    enable_b = 1'b0; up_down_b = 1'b1; load_b = 1'b0; load_value_b = 16'h0000;
    cyc(2);
    chk("rst_count", 32'(count), 32'h00);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_roll", 32'(rollover), 32'h0);
    chk("rst_hex", 32'(hex), 32'({S0, S0}));

    // Count up 00..10, one step every 4 enabled edges
    reset = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        chk("up_notick", 32'(tick), 32'h0);
      end
      cyc(1);
      chk("up_count", 32'(count), 32'(((k / 10) << 4) | (k % 10)));
      chk("up_tick", 32'(tick), 32'h1);
    end
    chk("hex_10", 32'(hex), 32'({S1, S0}));
    chk("up_roll0", 32'(rollover), 32'h0);

    // Load 99, wrap up to 00
    load = 1'b1; load_value = 8'h99;
    cyc(1);
    chk("ld99_count", 32'(count), 32'h99);
    chk("ld99_tick", 32'(tick), 32'h0);
    load = 1'b0;
    cyc(4);
    chk("wrapup_count", 32'(count), 32'h00);
    chk("wrapup_tick", 32'(tick), 32'h1);
    chk("wrapup_roll", 32'(rollover), 32'h1);
    cyc(1);
    chk("wrapup_roll_pulse", 32'(rollover), 32'h0);
    chk("wrapup_tick_pulse", 32'(tick), 32'h0);
    cyc(3);
    chk("up01_count", 32'(count), 32'h01);
    chk("up01_roll", 32'(rollover), 32'h0);

    // Load 00, count down wraps to 99 then 98
    load = 1'b1; load_value = 8'h00; up_down = 1'b0;
    cyc(1);
    load = 1'b0;
    cyc(4);
    chk("wrapdn_count", 32'(count), 32'h99);
    chk("wrapdn_roll", 32'(rollover), 32'h1);
    cyc(4);
    chk("dn98_count", 32'(count), 32'h98);
    chk("dn98_roll", 32'(rollover), 32'h0);
    chk("dn98_tick", 32'(tick), 32'h1);

    // Freeze with prescaler at 2
    cyc(2);
    enable = 1'b0;
    cyc(10);
    chk("hold_count", 32'(count), 32'h98);
    chk("hold_tick", 32'(tick), 32'h0);
    enable = 1'b1;
    cyc(1);
    chk("resume1_count", 32'(count), 32'h98);
    chk("resume1_tick", 32'(tick), 32'h0);
    cyc(1);
    chk("resume2_count", 32'(count), 32'h97);
    chk("resume2_tick", 32'(tick), 32'h1);

    // Load 0x3A exactly when a step was due: load wins, illegal digit cleared
    up_down = 1'b1;
    cyc(3);
    load = 1'b1; load_value = 8'h3A;
    cyc(1);
    chk("ld3a_count", 32'(count), 32'h30);
    chk("ld3a_tick", 32'(tick), 32'h0);
    chk("ld3a_roll", 32'(rollover), 32'h0);
    load = 1'b0;
    cyc(3);
    chk("ld3a_wait", 32'(count), 32'h30);
    cyc(1);
    chk("ld3a_step", 32'(count), 32'h31);
    chk("ld3a_steptick", 32'(tick), 32'h1);

    // Reset overrides load
    reset = 1'b1; load = 1'b1; load_value = 8'h55;
    cyc(1);
    chk("rstld_count", 32'(count), 32'h00);
    chk("rstld_tick", 32'(tick), 32'h0);
    reset = 1'b0; load = 1'b0;

    // Leading-zero blanking on the 4-digit instance
    load_b = 1'b1; load_value_b = 16'h0042;
    cyc(1);
    chk("b_count42", 32'(count_b), 32'h0042);
    chk("b_hex42", 32'(hex_b), 32'({SB, SB, S4, S2}));
    load_value_b = 16'h0000;
    cyc(1);
    chk("b_hex0000", 32'(hex_b), 32'({SB, SB, SB, S0}));
    load_value_b = 16'h0402;
    cyc(1);
    chk("b_hex0402", 32'(hex_b), 32'({SB, S4, S0, S2}));
    load_value_b = 16'h10F1;
    cyc(1);
    chk("b_count10f1", 32'(count_b), 32'h1001);
    chk("b_hex1001", 32'(hex_b), 32'({S1, S0, S0, S1}));
    load_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
